// File: rtl/refresh_counter.sv
// refresh_counter: DRAM refresh timebase.
// Counts enabled clock cycles on a wide elapsed-cycle counter. It also emits a
// one-cycle refresh_flag pulse every REFRESH_INTERVAL enabled cycles.
// Optional build macro REFRESH_COUNTER_SAT_EN: when it is defined, count
// saturates at all-ones instead of wrapping. The interval counter and
// refresh_flag keep running either way.
module refresh_counter #(
  parameter int width            = 36,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             refresh_flag,
  output logic [width-1:0] count
);

  // Interval counter spans 0..REFRESH_INTERVAL-1.
  localparam int IVL_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(REFRESH_INTERVAL - 1);

  // Reject intervals that cannot produce a single-cycle pulse or that the
  // elapsed counter could never reach.
  generate
    if (width < 1 || width > 63) begin : g_bad_width
      $error("refresh_counter: width must be 1..63");
    end
    if (REFRESH_INTERVAL < 2) begin : g_bad_ivl_low
      $error("refresh_counter: REFRESH_INTERVAL must be >= 2");
    end
    if (width < 63 && 64'(REFRESH_INTERVAL) > ((64'd1 << width) - 64'd1)) begin : g_bad_ivl_high
      $error("refresh_counter: REFRESH_INTERVAL must be <= 2^width-1");
    end
  endgenerate

  logic [width-1:0] count_q, count_d;
  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic             flag_q, flag_d;
  logic             ivl_last;

  assign ivl_last = (ivl_q == IVL_LAST);

  // Next-state logic: hold when disabled, and never let a pulse stretch.
  always_comb begin
    count_d = count_q;
    ivl_d   = ivl_q;
    flag_d  = 1'b0;
    if (en) begin
`ifdef REFRESH_COUNTER_SAT_EN
      if (count_q != {width{1'b1}}) begin
        count_d = count_q + width'(1);
      end
`else
      count_d = count_q + width'(1);
`endif
      if (ivl_last) begin
        ivl_d  = '0;
        flag_d = 1'b1;
      end else begin
        ivl_d  = ivl_q + IVL_W'(1);
      end
    end
  end

  // State registers; reset discards any partial interval and overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ivl_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ivl_q   <= ivl_d;
      flag_q  <= flag_d;
    end
  end

  assign count        = count_q;
  assign refresh_flag = flag_q;

endmodule

// File: tb/tb_refresh_counter.sv
// Testbench for refresh_counter. Two instances run side by side:
//   A: width=36, REFRESH_INTERVAL=8
//   B: width=4,  REFRESH_INTERVAL=5 (exercises the wrap, or saturation when
//      REFRESH_COUNTER_SAT_EN is defined)
// The reference model tracks the number of enabled edges since reset.
// Expected count and flag are derived from that number arithmetically.
module tb_refresh_counter;

  localparam int WA = 36;
  localparam int RA = 8;
  localparam int WB = 4;
  localparam int RB = 5;

  logic          clk = 1'b0;
  logic          rst_a, en_a, rst_b, en_b;
  logic          flag_a, flag_b;
  logic [WA-1:0] count_a;
  logic [WB-1:0] count_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: enabled edges since last reset, and expected pulse.
  longint n_a = 0, n_b = 0;
  logic   ef_a = 1'b0, ef_b = 1'b0;

  always #5 clk = ~clk;

  refresh_counter #(.width(WA), .REFRESH_INTERVAL(RA)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .refresh_flag(flag_a), .count(count_a)
  );

  refresh_counter #(.width(WB), .REFRESH_INTERVAL(RB)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .refresh_flag(flag_b), .count(count_b)
  );

  function automatic longint exp_count(input longint n, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
`ifdef REFRESH_COUNTER_SAT_EN
    return (n > top) ? top : n;
`else
    return n % (top + 1);
`endif
  endfunction

  // One clock: drive inputs, advance the model, and check both DUTs 1ns
  // after the edge.
  task automatic step(input logic ra, input logic ea, input logic rb, input logic eb);
    longint ec_a, ec_b;
    rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
    @(posedge clk);
    if (ra) begin n_a = 0; ef_a = 1'b0; end
    else if (ea) begin n_a++; ef_a = (n_a % RA == 0); end
    else ef_a = 1'b0;
    if (rb) begin n_b = 0; ef_b = 1'b0; end
    else if (eb) begin n_b++; ef_b = (n_b % RB == 0); end
    else ef_b = 1'b0;
    #1;
    ec_a = exp_count(n_a, WA);
    ec_b = exp_count(n_b, WB);
    n_checks++;
    assert (count_a === WA'(ec_a)) else begin
      n_fail++; $error("FAIL count_a: got %0d expected %0d", count_a, ec_a);
    end
    n_checks++;
    assert (flag_a === ef_a) else begin
      n_fail++; $error("FAIL flag_a: got %b expected %b (n=%0d)", flag_a, ef_a, n_a);
    end
    n_checks++;
    assert (count_b === WB'(ec_b)) else begin
      n_fail++; $error("FAIL count_b: got %0d expected %0d", count_b, ec_b);
    end
    n_checks++;
    assert (flag_b === ef_b) else begin
      n_fail++; $error("FAIL flag_b: got %b expected %b (n=%0d)", flag_b, ef_b, n_b);
    end
    $display("t=%0t rstA=%b enA=%b countA=%0d flagA=%b | rstB=%b enB=%b countB=%0d flagB=%b",
             $time, ra, ea, count_a, flag_a, rb, eb, count_b, flag_b);
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;

    // Reset held with en high: both stay cleared.
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);

    // Periodic pulse on A (count 8, 16, 24). Wrap or saturation on B:
    // 20 enabled cycles, with pulses at 5, 10, 15 and the 20th edge.
    for (int i = 0; i < 26; i++) step(0, 1, 0, (i < 20) ? 1'b1 : 1'b0);

    // Enable gating on A: 5 on, 10 off, then on until past the pulse.
    step(1, 1, 1, 0);
    for (int i = 0; i < 5; i++)  step(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++)  step(0, 1, 0, 1);

    // Reset mid-interval: 6 enabled cycles, 1 reset cycle with en high, then
    // a full interval more.
    step(1, 1, 1, 1);
    for (int i = 0; i < 6; i++)  step(0, 1, 0, 1);
    step(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1);

    // Randomized enable with occasional reset.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0));

    // Long enabled run on B to revisit wrap or saturation.
    step(1, 1, 1, 1);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/refresh_counter.md
Name: refresh_counter

Overview:
- DRAM refresh timebase for the controller.
- Counts enabled clock cycles on a wide elapsed-cycle counter.
- Emits a one-cycle `refresh_flag` pulse every REFRESH_INTERVAL enabled cycles; the refresh scheduler consumes this pulse.
- Single clock domain, no handshake, purely registered outputs.

Parameters:
- width, 36: width of the elapsed-cycle output `count`.
- REFRESH_INTERVAL, 780: enabled cycles between refresh pulses (7.8 us at 100 MHz). Legal range 2 .. 2^width-1; out-of-range is an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; state advances only when high.
- refresh_flag  output  1  registered one-cycle refresh request pulse.
- count  output  width  registered elapsed enabled-cycle count.

Behaviour:
- Internal interval counter `ivl`, width $clog2(REFRESH_INTERVAL), range 0..REFRESH_INTERVAL-1; not a port.
- Reset (rst=1 at rising edge): count=0, ivl=0, refresh_flag=0. Reset has priority over en.
- Reset mid-operation discards any partial interval; the next pulse comes REFRESH_INTERVAL enabled cycles after release.
- en=1, rst=0, each rising edge:
  - count <= count+1, modulo 2^width; wraps from all-ones to 0 with no side effect.
  - If ivl==REFRESH_INTERVAL-1: ivl <= 0 and refresh_flag <= 1.
  - Otherwise: ivl <= ivl+1 and refresh_flag <= 0.
- en=0, rst=0: count and ivl hold; refresh_flag <= 0. A pulse is never stretched by en dropping.
- Latency: with en held high from reset release, refresh_flag is high on exactly the cycle following the REFRESH_INTERVAL-th enabled edge. At that time count==REFRESH_INTERVAL.
- Pulses repeat every REFRESH_INTERVAL enabled edges: count==k*REFRESH_INTERVAL while the flag is high, for k=1,2,...
- refresh_flag is never high for two consecutive cycles; guaranteed because REFRESH_INTERVAL>=2.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: REFRESH_COUNTER_SAT_EN.
- Defined: count saturates at 2^width-1 and holds there while en=1; only rst clears it. ivl and refresh_flag continue unaffected by saturation.
- Undefined (default): count wraps modulo 2^width as specified above.

Test Plan:
- Reset: rst=1, en=1 for 5 cycles -> count=0 and refresh_flag=0 every cycle.
- Periodic pulse, REFRESH_INTERVAL=8: release rst, en=1 -> refresh_flag high for exactly one cycle with count=8, again at count=16 and 24, low otherwise.
- Enable gating, REFRESH_INTERVAL=8: en=1 for 5 cycles, en=0 for 10 cycles, en=1 -> count holds 5 while en=0; pulse appears with count=8 after 3 further enabled cycles.
- Reset mid-interval, REFRESH_INTERVAL=8: en=1 for 6 cycles, rst=1 for 1 cycle with en=1 -> count=0, no pulse; next pulse when count=8.
- Wrap, width=4, REFRESH_INTERVAL=5: en=1 for 20 cycles -> count goes 15 then 0; pulses at count 5, 10, 15 and 4 (the 20th cycle).
- With REFRESH_COUNTER_SAT_EN, width=4: en=1 for 20 cycles -> count stops at 15; refresh_flag keeps pulsing every 5 cycles.
